wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone (pipelined) round-robin arbiter in front of one shared slave.
// A grant is held until its owner drops cyc; ties go to the master that did not own the bus last.
module wb_rr_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;

  // Release by the current owner is resolved before any new request, so the other master wins.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_d = last_owner_q ? GRANT0 : GRANT1;
        end else if (m0_wb_cyc_i) begin
          state_d = GRANT0;
        end else if (m1_wb_cyc_i) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        if (!m0_wb_cyc_i) begin
          last_owner_d = 1'b0;
          state_d      = m1_wb_cyc_i ? GRANT1 : IDLE;
        end else begin
          state_d = GRANT0;
        end
      end
      GRANT1: begin
        if (!m1_wb_cyc_i) begin
          last_owner_d = 1'b1;
          state_d      = m0_wb_cyc_i ? GRANT0 : IDLE;
        end else begin
          state_d = GRANT1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Request path and response path are pure muxes on the grant state; nothing is registered here.
  always_comb begin
    s_wb_adr_o    = 32'h0000_0000;
    s_wb_dat_o    = 32'h0000_0000;
    s_wb_sel_o    = 4'h0;
    s_wb_we_o     = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_dat_o   = 32'h0000_0000;
    m0_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_dat_o   = 32'h0000_0000;
    m1_wb_ack_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    case (state_q)
      GRANT0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_stb_o    = m0_wb_stb_i;
        s_wb_cyc_o    = m0_wb_cyc_i;
        m0_wb_dat_o   = s_wb_dat_i;
        m0_wb_ack_o   = s_wb_ack_i;
        m0_wb_stall_o = s_wb_stall_i;
      end
      GRANT1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_stb_o    = m1_wb_stb_i;
        s_wb_cyc_o    = m1_wb_cyc_i;
        m1_wb_dat_o   = s_wb_dat_i;
        m1_wb_ack_o   = s_wb_ack_i;
        m1_wb_stall_o = s_wb_stall_i;
      end
      default: begin
        s_wb_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: scenario tasks with inline checks plus a slave-side scoreboard
// that compares every accepted request beat against the expected issue order.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_stall_i;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel), .m0_wb_we_i(m0_we),
    .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc), .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack_o),
    .m0_wb_stall_o(m0_stall_o),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we),
    .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc), .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack_o),
    .m1_wb_stall_o(m1_stall_o),
    .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o), .s_wb_sel_o(s_sel_o), .s_wb_we_o(s_we_o),
    .s_wb_stb_o(s_stb_o), .s_wb_cyc_o(s_cyc_o), .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack_i),
    .s_wb_stall_i(s_stall_i)
  );

  // Scoreboard consumer: every beat the slave accepts must be the next expected one.
  initial begin : sb_monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b0 && s_cyc_o === 1'b1 && s_stb_o === 1'b1 && s_stall_i === 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_beat: got adr=%h we=%b, expected no beat", s_adr_o, s_we_o);
        end else begin
          e = exp_q.pop_front();
          if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== e)
            $display("FAIL sb_beat: got adr=%h dat=%h sel=%h we=%b, expected adr=%h dat=%h sel=%h we=%b",
                     s_adr_o, s_dat_o, s_sel_o, s_we_o, e.adr, e.dat, e.sel, e.we);
          else n_pass++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we);
    beat_t b;
    b.adr = adr; b.dat = dat; b.sel = sel; b.we = we;
    exp_q.push_back(b);
  endtask

  task automatic drive_m0(input logic cyc, input logic stb, input logic [31:0] adr,
                          input logic [31:0] dat, input logic we);
    m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_dat = dat; m0_we = we; m0_sel = 4'hF;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic [31:0] adr,
                          input logic [31:0] dat, input logic we);
    m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_dat = dat; m1_we = we; m1_sel = 4'hF;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    s_dat_i = 32'h0; s_ack_i = 1'b0; s_stall_i = 1'b0;
    cyc_step();
    cyc_step();
    rst_i = 1'b0;
    m0_stb = 1'b1;
    s_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000)
      $display("FAIL reset_ctrl: got cyc/stb/we=%b, expected 000", {s_cyc_o, s_stb_o, s_we_o});
    else n_pass++;
    n_checks++;
    if ({s_adr_o, s_dat_o, s_sel_o} !== 68'h0)
      $display("FAIL reset_bus: got adr=%h dat=%h sel=%h, expected zeros", s_adr_o, s_dat_o, s_sel_o);
    else n_pass++;
    n_checks++;
    if ({m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o} !== 4'b1100)
      $display("FAIL reset_master: got stall0/stall1/ack0/ack1=%b, expected 1100 (idle ack discarded)",
               {m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o});
    else n_pass++;
    cyc_step();
    n_checks++;
    if ({s_cyc_o, s_stb_o, m0_ack_o, m0_stall_o} !== 4'b0001)
      $display("FAIL stb_without_cyc: got cyc/stb/ack0/stall0=%b, expected 0001",
               {s_cyc_o, s_stb_o, m0_ack_o, m0_stall_o});
    else n_pass++;
    m0_stb = 1'b0;
    s_ack_i = 1'b0;
  endtask

  task automatic test_tie_write();
    cyc_step();
    drive_m0(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    drive_m1(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0);
    push(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    push(32'h0000_0020, 32'h0000_0000, 4'hF, 1'b0);
    #1;
    n_checks++;
    if (s_stb_o !== 1'b0) $display("FAIL grant_latency: got s_stb_o=%b in request cycle, expected 0", s_stb_o);
    else n_pass++;
    cyc_step();
    n_checks++;
    if ({s_adr_o, s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o} !== {32'h0000_0010, 4'b1101})
      $display("FAIL tie_grant0: got adr=%h cyc/stb/stall0/stall1=%b, expected 00000010 1101",
               s_adr_o, {s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o});
    else n_pass++;
    cyc_step();
    m0_stb = 1'b0;
    #1;
    n_checks++;
    if (m0_ack_o !== 1'b0) $display("FAIL write_early_ack: got m0_ack=%b, expected 0", m0_ack_o);
    else n_pass++;
    cyc_step();
    s_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10)
      $display("FAIL write_ack: got ack0/ack1=%b, expected 10", {m0_ack_o, m1_ack_o});
    else n_pass++;
    cyc_step();
    s_ack_i = 1'b0;
    #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b00)
      $display("FAIL write_ack_pulse: got ack0/ack1=%b, expected 00", {m0_ack_o, m1_ack_o});
    else n_pass++;
  endtask

  task automatic test_handover_read();
    cyc_step();
    m0_cyc = 1'b0;
    cyc_step();
    n_checks++;
    if ({s_adr_o, s_we_o, s_stb_o, m0_stall_o, m1_stall_o} !== {32'h0000_0020, 4'b0110})
      $display("FAIL handover_grant1: got adr=%h we/stb/stall0/stall1=%b, expected 00000020 0110",
               s_adr_o, {s_we_o, s_stb_o, m0_stall_o, m1_stall_o});
    else n_pass++;
    cyc_step();
    m1_stb = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #1;
    n_checks++;
    if ({m1_dat_o, m1_ack_o, m0_ack_o, m0_dat_o} !== {32'h1234_5678, 2'b10, 32'h0})
      $display("FAIL read_data: got dat1=%h ack1/ack0=%b dat0=%h, expected 12345678 10 00000000",
               m1_dat_o, {m1_ack_o, m0_ack_o}, m0_dat_o);
    else n_pass++;
    cyc_step();
    s_ack_i = 1'b0; s_dat_i = 32'h0; m1_cyc = 1'b0;
    cyc_step();
    n_checks++;
    if ({s_cyc_o, m0_stall_o, m1_stall_o} !== 3'b011)
      $display("FAIL return_idle: got cyc/stall0/stall1=%b, expected 011", {s_cyc_o, m0_stall_o, m1_stall_o});
    else n_pass++;
  endtask

  // Two masters each issue two 4-beat write bursts back to back; expected slave order alternates.
  task automatic test_back_to_back();
    int beat[2], acks[2], bursts[2];
    logic rel[2], cyc_v[2], stb_v[2], stall_v[2], ack_v[2];
    logic [31:0] adr_v[2];
    logic [31:0] base[2];
    logic acc_prev;
    int cycles;
    base[0] = 32'h0000_1000; base[1] = 32'h0000_2000;
    for (int b = 0; b < 2; b++)
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < 4; k++)
          push(base[m] + 32'(b * 16 + k * 4), ~(base[m] + 32'(b * 16 + k * 4)), 4'hF, 1'b1);
    for (int m = 0; m < 2; m++) begin
      beat[m] = 0; acks[m] = 0; bursts[m] = 0; rel[m] = 1'b0;
    end
    acc_prev = 1'b0;
    cycles = 0;
    while (!(bursts[0] == 2 && bursts[1] == 2) && cycles < 200) begin
      cyc_step();
      cycles++;
      for (int m = 0; m < 2; m++) begin
        if (rel[m] || bursts[m] == 2) begin
          cyc_v[m] = 1'b0; stb_v[m] = 1'b0; rel[m] = 1'b0;
        end else begin
          cyc_v[m] = 1'b1; stb_v[m] = (beat[m] < 4);
        end
        adr_v[m] = base[m] + 32'(bursts[m] * 16 + beat[m] * 4);
      end
      drive_m0(cyc_v[0], stb_v[0], adr_v[0], ~adr_v[0], 1'b1);
      drive_m1(cyc_v[1], stb_v[1], adr_v[1], ~adr_v[1], 1'b1);
      s_ack_i = acc_prev;
      #1;
      acc_prev = s_cyc_o && s_stb_o && !s_stall_i;
      stall_v[0] = m0_stall_o; stall_v[1] = m1_stall_o;
      ack_v[0] = m0_ack_o; ack_v[1] = m1_ack_o;
      for (int m = 0; m < 2; m++) begin
        if (stb_v[m] && !stall_v[m]) beat[m]++;
        if (ack_v[m]) begin
          acks[m]++;
          if (acks[m] == 4) begin
            bursts[m]++; beat[m] = 0; acks[m] = 0; rel[m] = 1'b1;
          end
        end
      end
    end
    n_checks++;
    if (!(bursts[0] == 2 && bursts[1] == 2))
      $display("FAIL burst_timeout: got bursts m0=%0d m1=%0d after %0d cycles, expected 2 and 2",
               bursts[0], bursts[1], cycles);
    else n_pass++;
    cyc_step();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    s_ack_i = 1'b0;
    cyc_step();
  endtask

  task automatic test_stall();
    drive_m1(1'b1, 1'b1, 32'h0000_0300, 32'h0, 1'b0);
    push(32'h0000_0300, 32'h0, 4'hF, 1'b0);
    cyc_step();
    drive_m0(1'b1, 1'b1, 32'h0000_0400, 32'h0000_0044, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s_stall_i = 1'b1;
      #1;
      n_checks++;
      if ({s_adr_o, m1_stall_o, m0_stall_o} !== {32'h0000_0300, 2'b11})
        $display("FAIL stall_hold_%0d: got adr=%h stall1/stall0=%b, expected 00000300 11",
                 i, s_adr_o, {m1_stall_o, m0_stall_o});
      else n_pass++;
      cyc_step();
    end
    s_stall_i = 1'b0;
    #1;
    n_checks++;
    if ({s_adr_o, m1_stall_o, m0_stall_o} !== {32'h0000_0300, 2'b01})
      $display("FAIL stall_release: got adr=%h stall1/stall0=%b, expected 00000300 01",
               s_adr_o, {m1_stall_o, m0_stall_o});
    else n_pass++;
    cyc_step();
    m1_stb = 1'b0; s_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({m1_ack_o, m0_ack_o, m0_stall_o} !== 3'b101)
      $display("FAIL stall_ack: got ack1/ack0/stall0=%b, expected 101", {m1_ack_o, m0_ack_o, m0_stall_o});
    else n_pass++;
    cyc_step();
    s_ack_i = 1'b0; m1_cyc = 1'b0;
    push(32'h0000_0400, 32'h0000_0044, 4'hF, 1'b1);
    cyc_step();
    n_checks++;
    if ({s_adr_o, s_we_o} !== {32'h0000_0400, 1'b1})
      $display("FAIL waiting_m0_grant: got adr=%h we=%b, expected 00000400 1", s_adr_o, s_we_o);
    else n_pass++;
    cyc_step();
    m0_stb = 1'b0; s_ack_i = 1'b1;
    cyc_step();
    s_ack_i = 1'b0; m0_cyc = 1'b0;
    cyc_step();
  endtask

  task automatic test_reset_mid();
    drive_m1(1'b1, 1'b1, 32'h0000_0500, 32'h0, 1'b0);
    push(32'h0000_0500, 32'h0, 4'hF, 1'b0);
    cyc_step();
    n_checks++;
    if (s_adr_o !== 32'h0000_0500) $display("FAIL pre_reset_grant1: got adr=%h, expected 00000500", s_adr_o);
    else n_pass++;
    cyc_step();
    m1_stb = 1'b0; rst_i = 1'b1;
    cyc_step();
    rst_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
    drive_m0(1'b1, 1'b1, 32'h0000_0600, 32'h0000_0066, 1'b1);
    push(32'h0000_0600, 32'h0000_0066, 4'hF, 1'b1);
    #1;
    n_checks++;
    if ({s_cyc_o, m1_ack_o, m0_ack_o, m1_stall_o, m1_dat_o} !== {4'b0001, 32'h0})
      $display("FAIL reset_abort: got cyc/ack1/ack0/stall1=%b dat1=%h, expected 0001 00000000",
               {s_cyc_o, m1_ack_o, m0_ack_o, m1_stall_o}, m1_dat_o);
    else n_pass++;
    cyc_step();
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    #1;
    n_checks++;
    if ({s_adr_o, m1_stall_o, m0_stall_o} !== {32'h0000_0600, 2'b10})
      $display("FAIL reset_tie_m0: got adr=%h stall1/stall0=%b, expected 00000600 10",
               s_adr_o, {m1_stall_o, m0_stall_o});
    else n_pass++;
    cyc_step();
    m0_stb = 1'b0; s_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10)
      $display("FAIL post_reset_ack: got ack0/ack1=%b, expected 10", {m0_ack_o, m1_ack_o});
    else n_pass++;
    cyc_step();
    s_ack_i = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
    cyc_step();
    cyc_step();
  endtask

  initial begin
    test_reset();
    test_tie_write();
    test_handover_read();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d beats not seen, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
